// File: rtl/bp_pkg.sv
// Shared types and parameter defaults for the gshare branch predictor.
package bp_pkg;
    typedef enum logic {INIT, RUN} bp_state_e;

    localparam int BP_INDEX_BITS = 4;
    localparam int BP_CTR_BITS   = 2;
    localparam int BP_HIST_BITS  = 4;
endpackage

// File: rtl/bp_sat_counter.sv
// Combinational saturating up/down counter step.
module bp_sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] cur_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] next_o
);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    always_comb begin
        next_o = cur_i;
        if (taken_i && (cur_i != CTR_MAX))
            next_o = cur_i + 1'b1;
        else if (!taken_i && (cur_i != '0))
            next_o = cur_i - 1'b1;
    end
endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: PC xor global history indexes a table of saturating counters,
// initialised by a post-reset sweep before predictions are enabled.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int CTR_BITS   = BP_CTR_BITS,
    parameter int HIST_BITS  = BP_HIST_BITS,
    parameter int INIT_VALUE = 2**(CTR_BITS-1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_decode_sig,
    input  logic        branch_mem_sig,
    input  logic        actual_branch_decision,
    input  logic [31:0] pc_branch_addr,
    input  logic [31:0] offset,
    input  logic [31:0] update_branch_addr,
    output logic [31:0] out_branch_addr,
    output logic        prediction,
    output logic        ready
);
    localparam int DEPTH = 2**INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_PTR = INDEX_BITS'(DEPTH-1);

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [CTR_BITS-1:0]   table_q [DEPTH];
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] lookup_idx, upd_idx;
    logic [CTR_BITS-1:0]   ctr_next;
    logic                  upd_en;
    logic                  unused_upd_bits;

    assign unused_upd_bits = ^update_branch_addr[31:INDEX_BITS];

    assign ready      = (state_q == RUN);
    assign upd_en     = branch_mem_sig & ready;
    assign lookup_idx = pc_branch_addr[INDEX_BITS-1:0] ^ ghr_ext;
    assign upd_idx    = update_branch_addr[INDEX_BITS-1:0] ^ ghr_ext;

    // Async read: a same-cycle update to this entry is seen only next cycle.
    assign prediction      = table_q[lookup_idx][CTR_BITS-1] & branch_decode_sig & ready;
    assign out_branch_addr = pc_branch_addr + offset;

    generate
        if (HIST_BITS > 0) begin : g_ghr
            logic [HIST_BITS-1:0] ghr_q, ghr_d;
            logic [HIST_BITS:0]   ghr_shift;

            assign ghr_shift = {ghr_q, actual_branch_decision};
            assign ghr_ext   = INDEX_BITS'(ghr_q);

            always_comb begin
                ghr_d = ghr_q;
                if (upd_en)
                    ghr_d = ghr_shift[HIST_BITS-1:0];
            end

            always_ff @(posedge clk) begin
                if (reset) ghr_q <= '0;
                else       ghr_q <= ghr_d;
            end
        end else begin : g_no_ghr
            assign ghr_ext = '0;
        end
    endgenerate

    bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
        .cur_i   (table_q[upd_idx]),
        .taken_i (actual_branch_decision),
        .next_o  (ctr_next)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR)
                    state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // No reset on the table: its contents come only from the sweep.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            table_q[ptr_q] <= CTR_BITS'(INIT_VALUE);
        else if (upd_en)
            table_q[upd_idx] <= ctr_next;
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for the gshare predictor: a default instance and a bimodal one.
module tb_gshare_branch_predictor;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_decode_sig = 1'b0;
    logic        branch_mem_sig = 1'b0;
    logic        actual_branch_decision = 1'b0;
    logic [31:0] pc_branch_addr = '0;
    logic [31:0] offset = '0;
    logic [31:0] update_branch_addr = '0;
    logic [31:0] out_branch_addr, out_bm;
    logic        prediction, pred_bm;
    logic        ready, ready_bm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor dut (
        .clk(clk), .reset(reset), .branch_decode_sig(branch_decode_sig),
        .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
        .pc_branch_addr(pc_branch_addr), .offset(offset),
        .update_branch_addr(update_branch_addr), .out_branch_addr(out_branch_addr),
        .prediction(prediction), .ready(ready)
    );

    gshare_branch_predictor #(.HIST_BITS(0)) dut_bm (
        .clk(clk), .reset(reset), .branch_decode_sig(branch_decode_sig),
        .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
        .pc_branch_addr(pc_branch_addr), .offset(offset),
        .update_branch_addr(update_branch_addr), .out_branch_addr(out_bm),
        .prediction(pred_bm), .ready(ready_bm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] addr, input logic taken);
        branch_mem_sig = 1'b1;
        update_branch_addr = addr;
        actual_branch_decision = taken;
        tick();
        branch_mem_sig = 1'b0;
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        branch_decode_sig = 1'b1;
        pc_branch_addr = pc;
        #1;
    endtask

    task automatic reset_and_sweep();
        branch_mem_sig = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (16) tick();
    endtask

    task automatic test_reset();
        logic [31:0] pcs [4];
        pcs = '{32'h0, 32'h7, 32'hA, 32'hF};
        branch_decode_sig = 1'b1;
        pc_branch_addr = 32'h3;
        reset = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0 || ready_bm !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b/%b exp=0", ready, ready_bm);
        end
        checks++;
        if (prediction !== 1'b0) begin
            failures++;
            $display("FAIL reset_pred got=%b exp=0", prediction);
        end
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (ready !== (i == 16) || ready_bm !== (i == 16)) begin
                failures++;
                $display("FAIL sweep_ready edge=%0d got=%b/%b exp=%b", i, ready, ready_bm, (i == 16));
            end
            checks++;
            if (prediction !== (i == 16)) begin
                failures++;
                $display("FAIL sweep_pred edge=%0d got=%b exp=%b", i, prediction, (i == 16));
            end
        end
        foreach (pcs[k]) begin
            lookup(pcs[k]);
            checks++;
            if (prediction !== 1'b1 || pred_bm !== 1'b1) begin
                failures++;
                $display("FAIL init_pred pc=%h got=%b/%b exp=1", pcs[k], prediction, pred_bm);
            end
        end
        branch_decode_sig = 1'b0;
        #1;
        checks++;
        if (prediction !== 1'b0) begin
            failures++;
            $display("FAIL nodecode_pred got=%b exp=0", prediction);
        end
    endtask

    task automatic test_target();
        pc_branch_addr = 32'hFFFF_FFF0;
        offset = 32'h20;
        #1;
        checks++;
        if (out_branch_addr !== 32'h0000_0010) begin
            failures++;
            $display("FAIL target_wrap got=%h exp=00000010", out_branch_addr);
        end
        pc_branch_addr = 32'h0000_1000;
        offset = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (out_branch_addr !== 32'h0000_0FFC) begin
            failures++;
            $display("FAIL target_neg got=%h exp=00000ffc", out_branch_addr);
        end
        offset = '0;
    endtask

    task automatic test_bimodal();
        logic [8:0] taken_seq;
        logic [8:0] exp_seq;
        taken_seq = 9'b1_1000_0111;
        exp_seq   = 9'b1_0000_1111;
        for (int i = 0; i < 9; i++) begin
            branch_decode_sig = 1'b0;
            resolve(32'h5, taken_seq[i]);
            lookup(32'h5);
            checks++;
            if (pred_bm !== exp_seq[i]) begin
                failures++;
                $display("FAIL bimodal step=%0d taken=%b got=%b exp=%b", i, taken_seq[i], pred_bm, exp_seq[i]);
            end
        end
        lookup(32'h4);
        checks++;
        if (pred_bm !== 1'b1) begin
            failures++;
            $display("FAIL bimodal_other got=%b exp=1", pred_bm);
        end
    endtask

    task automatic test_ghr();
        branch_decode_sig = 1'b0;
        reset_and_sweep();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ghr_ready got=%b exp=1", ready);
        end
        // idx: 0^0=0 (T), 0^1=1 (T), E^3=D (N), 0^6=6 (T); GHR ends 1101
        resolve(32'h0, 1'b1);
        resolve(32'h0, 1'b1);
        resolve(32'hE, 1'b0);
        resolve(32'h0, 1'b1);
        lookup(32'h0);
        checks++;
        if (prediction !== 1'b0) begin
            failures++;
            $display("FAIL ghr_entry_d got=%b exp=0", prediction);
        end
        lookup(32'hD);
        checks++;
        if (prediction !== 1'b1) begin
            failures++;
            $display("FAIL ghr_entry_0 got=%b exp=1", prediction);
        end
    endtask

    task automatic test_collision();
        // GHR=1101, entry D=1: lookup pc 0 and update addr 0 both hit entry D
        lookup(32'h0);
        branch_mem_sig = 1'b1;
        update_branch_addr = 32'h0;
        actual_branch_decision = 1'b1;
        #1;
        checks++;
        if (prediction !== 1'b0) begin
            failures++;
            $display("FAIL collide_same got=%b exp=0", prediction);
        end
        tick();
        branch_mem_sig = 1'b0;
        lookup(32'h6);
        checks++;
        if (prediction !== 1'b1) begin
            failures++;
            $display("FAIL collide_next got=%b exp=1", prediction);
        end
    endtask

    task automatic test_reset_mid_sweep();
        branch_decode_sig = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_ready got=%b exp=0", ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            branch_mem_sig = (i == 3) || (i == 4) || (i == 16);
            update_branch_addr = (i == 16) ? 32'h3 : 32'h9;
            actual_branch_decision = (i != 16);
            tick();
            branch_mem_sig = 1'b0;
            checks++;
            if (ready !== (i == 16)) begin
                failures++;
                $display("FAIL restart_ready edge=%0d got=%b exp=%b", i, ready, (i == 16));
            end
        end
        resolve(32'h5, 1'b0);
        lookup(32'h5);
        checks++;
        if (prediction !== 1'b0) begin
            failures++;
            $display("FAIL init_ghr_hold got=%b exp=0", prediction);
        end
        lookup(32'h3);
        checks++;
        if (prediction !== 1'b1) begin
            failures++;
            $display("FAIL init_no_write got=%b exp=1", prediction);
        end
        lookup(32'h4);
        checks++;
        if (prediction !== 1'b1) begin
            failures++;
            $display("FAIL init_neighbor got=%b exp=1", prediction);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_target();
        test_bimodal();
        test_ghr();
        test_collision();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
